// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter: state encoding,
// widths and the rotating-priority winner search.
package mux_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First set bit of req scanning upward from ptr, wrapping 15->0.
    // Walking downward lets the lowest offset overwrite the result last.
    function automatic logic [SEL_W-1:0] next_winner(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        win = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_mux.sv
// 16:1 single-bit mux datapath; y = in[sel], purely combinational.
module mux16_1_generate (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        y
);

    logic [15:0] hit;

    for (genvar gi = 0; gi < 16; gi++) begin : g_leg
        assign hit[gi] = (sel == 4'(gi)) & in[gi];
    end

    assign y = |hit;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux.
// Define MUX_ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles when others wait.
import mux_arb_pkg::*;

module mux16_rr_arbiter #(
    parameter int         MAX_HOLD = 8,
    parameter logic [3:0] PARK     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic [15:0] in,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic [3:0]  sel,
    output logic        y
);

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic               gnt_valid_reg, gnt_valid_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic               grant_now;
    logic [N_REQ-1:0]   grant_mask;
    logic [SEL_W-1:0]   winner;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0]         cnt_reg, cnt_next;
    logic [N_REQ-1:0]   others;
`else
    logic [7:0]         unused_max_hold;
    assign unused_max_hold = 8'(MAX_HOLD);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            sel_reg       <= PARK;
            ptr_reg       <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            sel_reg       <= sel_next;
            ptr_reg       <= ptr_next;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_reg       <= cnt_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_valid_next = gnt_valid_reg;
        sel_next       = sel_reg;
        ptr_next       = ptr_reg;
        grant_now      = 1'b0;
        grant_mask     = req;
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_next       = cnt_reg;
        others         = req & ~gnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                grant_now = |req;
            end
            ST_GRANT: begin
                if (req[sel_reg]) begin
`ifdef MUX_ARB_TIMEOUT_EN
                    // Hold limit reached: hand over only if somebody else is waiting.
                    if (cnt_reg == 8'(MAX_HOLD - 1)) begin
                        if (|others) begin
                            grant_now  = 1'b1;
                            grant_mask = others;
                        end else begin
                            cnt_next = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
`endif
                end else if (|req) begin
                    grant_now = 1'b1;
                end else begin
                    state_next     = ST_IDLE;
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    sel_next       = PARK;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        winner = next_winner(grant_mask, ptr_reg);
        if (grant_now) begin
            state_next     = ST_GRANT;
            sel_next       = winner;
            gnt_next       = N_REQ'(1) << winner;
            gnt_valid_next = 1'b1;
            ptr_next       = winner + SEL_W'(1);
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_next       = '0;
`endif
        end
    end

    always_comb begin
        gnt       = gnt_reg;
        gnt_valid = gnt_valid_reg;
        sel       = sel_reg;
    end

    mux16_1_generate u_mux (
        .in  (in),
        .sel (sel_reg),
        .y   (y)
    );

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: a queue-based reference model predicts
// each cycle's grant, a monitor compares after every rising edge.
module tb_mux16_rr_arbiter;

    localparam int         MAXH = 4;
    localparam logic [3:0] PRK  = 4'd6;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] in;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [3:0]  sel;
    logic        y;

    typedef struct packed {
        logic [15:0] gnt;
        logic        v;
        logic [3:0]  sel;
        logic        y;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    mux16_rr_arbiter #(.MAX_HOLD(MAXH), .PARK(PRK)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (in),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int win(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_grant(input logic [15:0] r);
        int w;
        w = win(r, m_ptr);
        m_owner = w;
        m_ptr   = (w + 1) % 16;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic i_rst);
        logic [15:0] others;
        if (i_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            if (r != 0) model_grant(r);
        end else if (r[m_owner]) begin
`ifdef MUX_ARB_TIMEOUT_EN
            others = r & ~(16'h1 << m_owner);
            if (m_hold == MAXH - 1) begin
                if (others != 0) model_grant(others);
                else m_hold = 0;
            end else begin
                m_hold++;
            end
`else
            others = '0;
`endif
        end else if (r != 0) begin
            model_grant(r);
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic drive(input logic [15:0] r, input logic [15:0] d, input logic i_rst);
        exp_t e;
        logic [3:0] s;
        @(negedge clk);
        req = r;
        in  = d;
        rst = i_rst;
        model_step(r, i_rst);
        s     = (m_owner < 0) ? PRK : 4'(m_owner);
        e.gnt = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
        e.v   = (m_owner >= 0);
        e.sel = s;
        e.y   = d[s];
        sb.push_back(e);
    endtask

    // monitor: one comparison per clock edge that has a pending expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || gnt_valid !== e.v || sel !== e.sel || y !== e.y) begin
                errors++;
                $display("FAIL txn %0d: got gnt=%h v=%b sel=%0d y=%b, want gnt=%h v=%b sel=%0d y=%b",
                         checks, gnt, gnt_valid, sel, y, e.gnt, e.v, e.sel, e.y);
            end else begin
                $display("txn %0d ok: req=%h gnt=%h v=%b sel=%0d y=%b",
                         checks, req, gnt, gnt_valid, sel, y);
            end
        end
    end

    initial begin
        logic [15:0] r;
        logic [15:0] d;
        rst = 1'b1;
        req = '0;
        in  = '0;

        // reset with all requesting, then release
        drive(16'hFFFF, 16'h1234, 1'b1);
        drive(16'hFFFF, 16'h1234, 1'b1);
        drive(16'hFFFF, 16'h1234, 1'b0);
        drive(16'hFFFF, 16'h1235, 1'b0);
        drive(16'h0000, 16'h1235, 1'b0);

        // single requester
        drive(16'h0020, 16'h0020, 1'b0);
        drive(16'h0020, 16'h0000, 1'b0);
        drive(16'h0000, 16'h0040, 1'b0);
        drive(16'h0000, 16'hFFBF, 1'b0);

        // rotation and wrap
        drive(16'h8001, 16'h8000, 1'b0);
        drive(16'h8001, 16'h8000, 1'b0);
        drive(16'h8000, 16'h8000, 1'b0);
        drive(16'h8001, 16'h0001, 1'b0);
        drive(16'h0001, 16'h0001, 1'b0);
        drive(16'h8001, 16'h0001, 1'b0);
        drive(16'h0000, 16'h0001, 1'b0);

        // data scan
        for (int i = 0; i < 16; i++) begin
            drive(16'h1 << i, 16'hA5A5, 1'b0);
            drive(16'h1 << i, 16'hA5A5, 1'b0);
            drive(16'h0000, 16'hA5A5, 1'b0);
        end

        // timeout pair, then sole requester
        for (int i = 0; i < 14; i++) drive(16'h0003, 16'h0001, 1'b0);
        drive(16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 12; i++) drive(16'h0004, 16'h0004, 1'b0);
        drive(16'h0000, 16'h0000, 1'b0);

        // reset mid-grant
        drive(16'h0200, 16'h0200, 1'b0);
        drive(16'h0200, 16'h0200, 1'b0);
        drive(16'h0200, 16'h0200, 1'b1);
        drive(16'h0201, 16'h0201, 1'b0);
        drive(16'h0201, 16'h0201, 1'b0);
        drive(16'h0200, 16'h0201, 1'b0);
        drive(16'h0000, 16'h0201, 1'b0);

        // randomized traffic
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            d = 16'($urandom);
            drive(r, d, ($urandom_range(0, 49) == 0));
        end

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
